// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbiter state encoding and mode codes shared by the arbiter files
package mem_arbiter_pkg;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_OWN = 1'b1} arb_state_e;
   localparam logic ARB_MODE_STATIC = 1'b0;
   localparam logic ARB_MODE_RR     = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker: rotate-priority encoder, lowest requesting index at or after ptr with wrap
module mem_arbiter_rr_picker #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] idx,
   output logic          found
);
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N]) begin
            idx   = SW'((int'(ptr) + k) % N);
            found = 1'b1;
         end
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shared-memory arbiter (static select or round-robin with burst limit); GENIE_ARB_PERF_EN adds per-engine transaction counters
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int N_ENG = 4,
   parameter int AW    = 26,
   parameter int DW    = 32,
   parameter int SW    = $clog2(N_ENG),
   parameter int BURST = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode,
   input  logic [SW-1:0]       sel,
   input  logic [N_ENG-1:0]    e_wvalid,
   output logic [N_ENG-1:0]    e_wready,
   input  logic [N_ENG*AW-1:0] e_waddr,
   input  logic [N_ENG*DW-1:0] e_wdata,
   input  logic [N_ENG-1:0]    e_rvalid,
   output logic [N_ENG-1:0]    e_rready,
   input  logic [N_ENG*AW-1:0] e_raddr,
   output logic [N_ENG*DW-1:0] e_rdata,
   output logic                wvalid,
   output logic [AW-1:0]       waddr,
   output logic [DW-1:0]       wdata,
   input  logic                wready,
   output logic                rvalid,
   output logic [AW-1:0]       raddr,
   input  logic                rready,
   input  logic [DW-1:0]       rdata,
   output logic                busy,
   output logic [SW-1:0]       grant_id,
   input  logic [SW-1:0]       perf_sel,
   output logic [31:0]         perf_cnt
);
   localparam int BW = $clog2(BURST + 1);
   arb_state_e state, state_nxt;
   logic [SW-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, rr_idx, cand;
   logic [BW-1:0] burst_cnt, burst_nxt, burst_inc;
   logic [N_ENG-1:0] req;
   logic mode_q, mode_nxt, rr_found, cand_ok, in_flight, others, release_now;
   logic [AW-1:0] wa [N_ENG];
   logic [AW-1:0] ra [N_ENG];
   logic [DW-1:0] wd [N_ENG];

   assign req = e_rvalid | e_wvalid;

   mem_arbiter_rr_picker #(.N(N_ENG), .SW(SW)) u_picker (
      .req   (req),
      .ptr   (rr_ptr),
      .idx   (rr_idx),
      .found (rr_found)
   );

   for (genvar i = 0; i < N_ENG; i++) begin : g_slot
      assign wa[i] = e_waddr[i*AW +: AW];
      assign ra[i] = e_raddr[i*AW +: AW];
      assign wd[i] = e_wdata[i*DW +: DW];
      assign e_wready[i] = busy && owner == SW'(i) && wready;
      assign e_rready[i] = busy && owner == SW'(i) && rready;
      assign e_rdata[i*DW +: DW] = (busy && owner == SW'(i)) ? rdata : '0;
   end

   assign busy     = state == ARB_OWN;
   assign grant_id = owner;
   assign wvalid   = busy && e_wvalid[owner];
   assign rvalid   = busy && e_rvalid[owner];
   assign waddr    = busy ? wa[owner] : '0;
   assign wdata    = busy ? wd[owner] : '0;
   assign raddr    = busy ? ra[owner] : '0;

   assign cand      = mode ? rr_idx : sel;
   assign cand_ok   = mode ? rr_found : req[sel];
   assign in_flight = (wvalid && !wready) || (rvalid && !rready);
   assign others    = |(req & ~({{(N_ENG-1){1'b0}}, 1'b1} << owner));
   assign burst_inc = (busy && (wready || rready) && burst_cnt != BW'(BURST)) ? burst_cnt + 1'b1 : burst_cnt;
   // the completion landing this cycle counts toward the limit, so a grant ends right after its BURST-th completion
   assign release_now = busy && !in_flight && (!req[owner]
                        || (mode_q == ARB_MODE_STATIC && sel != owner)
                        || (mode_q == ARB_MODE_RR && burst_inc == BW'(BURST) && others));

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      mode_nxt   = mode_q;
      burst_nxt  = burst_inc;
      if (state == ARB_IDLE && cand_ok) begin
         state_nxt = ARB_OWN;
         owner_nxt = cand;
         mode_nxt  = mode;
         burst_nxt = '0;
      end else if (release_now) begin
         state_nxt  = ARB_IDLE;
         owner_nxt  = '0;
         rr_ptr_nxt = (owner == SW'(N_ENG - 1)) ? '0 : owner + 1'b1;
         burst_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= ARB_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         mode_q    <= ARB_MODE_STATIC;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         mode_q    <= mode_nxt;
         burst_cnt <= burst_nxt;
      end

`ifdef GENIE_ARB_PERF_EN
   logic [31:0] perf [N_ENG];
   logic [32:0] perf_sum [N_ENG];

   always_comb
      for (int i = 0; i < N_ENG; i++)
         perf_sum[i] = {1'b0, perf[i]} + 33'(e_wready[i]) + 33'(e_rready[i]);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < N_ENG; i++) perf[i] <= '0;
      else
         for (int i = 0; i < N_ENG; i++) perf[i] <= perf_sum[i][32] ? '1 : perf_sum[i][31:0];

   assign perf_cnt = perf[perf_sel];
`else
   logic unused_perf_sel;
   assign unused_perf_sel = ^perf_sel;
   assign perf_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with BURST=4
module tb_mem_arbiter;
   localparam int N = 4, AW = 26, DW = 32, SW = 2;
   logic clk = 1'b0, rst_n = 1'b0, mode, wready, rready;
   logic [SW-1:0] sel, perf_sel, grant_id;
   logic [N-1:0] e_wvalid, e_wready, e_rvalid, e_rready;
   logic [N*AW-1:0] e_waddr, e_raddr;
   logic [N*DW-1:0] e_wdata, e_rdata;
   logic wvalid, rvalid, busy;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata, rdata;
   logic [31:0] perf_cnt;
   int checks = 0, failures = 0;
   logic [SW-1:0] rr_gid [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
   logic          rr_busy [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] perf_exp;

   mem_arbiter #(.N_ENG(N), .AW(AW), .DW(DW), .SW(SW), .BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .e_wvalid(e_wvalid), .e_wready(e_wready), .e_waddr(e_waddr), .e_wdata(e_wdata),
      .e_rvalid(e_rvalid), .e_rready(e_rready), .e_raddr(e_raddr), .e_rdata(e_rdata),
      .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wready(wready),
      .rvalid(rvalid), .raddr(raddr), .rready(rready), .rdata(rdata),
      .busy(busy), .grant_id(grant_id), .perf_sel(perf_sel), .perf_cnt(perf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      mode = 1'b0; sel = '0; perf_sel = '0;
      e_wvalid = '0; e_rvalid = '0; e_waddr = '0; e_raddr = '0; e_wdata = '0;
      wready = 1'b0; rready = 1'b0; rdata = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_mem", {wvalid, rvalid, waddr, raddr, wdata}, 0);
      chk("rst_perf", perf_cnt, 0);
      rst_n = 1'b1;
      // static read routed to engine 1 only
      sel = 2'd1;
      e_rvalid = 4'b0010;
      e_raddr[1*AW +: AW] = 26'h100;
      #1;
      chk("s_idle_rvalid", rvalid, 0);
      tick();
      chk("s_gid", grant_id, 1);
      chk("s_raddr", {rvalid, raddr}, {1'b1, 26'h100});
      tick();
      tick();
      rready = 1'b1;
      rdata = 32'hDEADBEEF;
      #1;
      chk("s_rready", e_rready, 4'b0010);
      chk("s_rdata", e_rdata, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
      tick();
      rready = 1'b0;
      e_rvalid = '0;
      #1;
      chk("s_drop_busy", {busy, rvalid}, 2'b10);
      tick();
      chk("s_release", {busy, grant_id}, 0);
      // round-robin, engines 0 and 2 continuously requesting
      do_reset();
      mode = 1'b1;
      e_rvalid = 4'b0101;
      rready = 1'b1;
      #1;
      chk("rr_idle", busy, 0);
      for (int c = 0; c < 11; c++) begin
         tick();
         chk($sformatf("rr_busy%0d", c), busy, rr_busy[c]);
         chk($sformatf("rr_gid%0d", c), grant_id, rr_gid[c]);
         chk($sformatf("rr_rdy%0d", c), e_rready, rr_busy[c] ? (4'b0001 << rr_gid[c]) : 4'b0000);
      end
      // lone round-robin requester keeps ownership beyond the burst limit
      do_reset();
      mode = 1'b1;
      e_wvalid = 4'b1000;
      wready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         tick();
         chk($sformatf("solo%0d", c), {busy, grant_id, e_wready}, {1'b1, 2'd3, 4'b1000});
      end
      chk("solo_burst_sat", dut.burst_cnt, 4);
      // static select change while a write is outstanding
      do_reset();
      sel = 2'd1;
      e_wvalid = 4'b0110;
      e_waddr[1*AW +: AW] = 26'h2A0;
      e_waddr[2*AW +: AW] = 26'h3B0;
      e_wdata[1*DW +: DW] = 32'h11111111;
      e_wdata[2*DW +: DW] = 32'h22222222;
      tick();
      sel = 2'd2;
      #1;
      chk("sw_own1", {grant_id, wvalid, waddr, wdata}, {2'd1, 1'b1, 26'h2A0, 32'h11111111});
      tick();
      chk("sw_hold", {busy, grant_id}, {1'b1, 2'd1});
      wready = 1'b1;
      #1;
      chk("sw_wready", e_wready, 4'b0010);
      tick();
      wready = 1'b0;
      e_wvalid = 4'b0100;
      #1;
      chk("sw_bubble", {busy, grant_id, wvalid}, 0);
      tick();
      chk("sw_own2", {busy, grant_id, waddr, wdata}, {1'b1, 2'd2, 26'h3B0, 32'h22222222});
      // asynchronous reset in the middle of a read
      e_rvalid = 4'b0100;
      e_raddr[2*AW +: AW] = 26'h155;
      #1;
      chk("ar_pre", {rvalid, raddr}, {1'b1, 26'h155});
      wready = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("ar_out", {busy, grant_id, wvalid, rvalid, waddr, raddr, wdata}, 0);
      chk("ar_rdy", {e_wready, e_rready}, 0);
      clear_inputs();
      mode = 1'b1;
      e_rvalid = 4'b1010;
      tick();
      rst_n = 1'b1;
      #1;
      chk("ar_idle", busy, 0);
      tick();
      chk("ar_grant", {busy, grant_id}, {1'b1, 2'd1});
      // transaction counter: 5 reads and 3 writes on engine 0
      do_reset();
      e_rvalid = 4'b0001;
      e_wvalid = 4'b0001;
      tick();
      for (int c = 0; c < 5; c++) begin
         rready = 1'b1;
         wready = (c < 3);
         tick();
      end
      rready = 1'b0;
      wready = 1'b0;
      #1;
`ifdef GENIE_ARB_PERF_EN
      perf_exp = 32'd8;
`else
      perf_exp = 32'd0;
`endif
      chk("perf0", perf_cnt, perf_exp);
      perf_sel = 2'd1;
      #1;
      chk("perf1", perf_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-memory arbiter between N layer engines (FC, CV, MP loaders and future engines) and the single external memory port. It replaces the static layer-type mux in the top level. Ownership is registered and follows either a decoder-supplied select (static mode) or round-robin with a burst limit. An optional per-engine transaction counter is available.

## Interface
- N_ENG, 4: number of engine ports.
- AW, 26: address width.
- DW, 32: data width.
- SW, $clog2(N_ENG): select/ID width.
- BURST, 16: maximum completed transactions per round-robin grant when another engine is waiting.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = static (owner = sel), 1 = round-robin.
- sel  in  SW  static-mode owner, driven by the decoder from layer type.
- e_wvalid  in  N_ENG  per-engine write request.
- e_wready  out  N_ENG  per-engine write completion pulse.
- e_waddr  in  N_ENG*AW  packed write addresses; engine i at [i*AW +: AW].
- e_wdata  in  N_ENG*DW  packed write data.
- e_rvalid  in  N_ENG  per-engine read request.
- e_rready  out  N_ENG  per-engine read completion pulse.
- e_raddr  in  N_ENG*AW  packed read addresses.
- e_rdata  out  N_ENG*DW  per-engine read data; zero for non-owners.
- wvalid, waddr, wdata  out  1/AW/DW  memory write request.
- wready  in  1  memory write completion pulse.
- rvalid, raddr  out  1/AW  memory read request.
- rready  in  1  memory read completion pulse.
- rdata  in  DW  memory read data, valid with rready.
- busy  out  1  an owner is granted.
- grant_id  out  SW  current owner; 0 when idle.
- perf_sel  in  SW  counter read select.
- perf_cnt  out  32  completed-transaction count of engine perf_sel.

## Operation
- Protocol:
  - A requester holds valid/addr/data stable until its ready pulse arrives.
  - A ready pulse is one cycle long and completes exactly one transaction.
  - Read and write may be in flight together; they are forwarded independently.
- States:
  - IDLE → OWN when a candidate exists.
  - OWN → IDLE on release.
- Candidate selection:
  - Static mode: the candidate is sel, if that engine has rvalid or wvalid.
  - Round-robin mode: the candidate is the lowest requesting index at or after rr_ptr, with wrap-around.
- In OWN, only the owner's request signals reach memory. wready, rready and rdata route only to the owner; all other engines see 0.
- in_flight = memory rvalid or wvalid high and its ready not yet seen. No state change happens while in_flight.
- Release from OWN (evaluated only when in_flight is false):
  - the owner has no valid; or
  - static mode and sel ≠ owner; or
  - round-robin mode, burst_cnt == BURST, and another engine is requesting.
- On release:
  - rr_ptr ← owner+1 (mod N_ENG);
  - burst_cnt ← 0.
- burst_cnt increments on each owner ready pulse and saturates at BURST.
- Changes to mode and sel take effect only at release or IDLE.
- Reset (async, any time):
  - state ← IDLE; rr_ptr, burst_cnt, grant_id and counters ← 0; all outputs 0.
  - Any in-flight transaction is abandoned. Memory is reset together with the engines.

## Timing
- Grant latency: engine valid in IDLE at cycle t → memory valid combinationally at t+1.
- Memory wready/rready/rdata reach the owner combinationally, in the same cycle.
- Release takes one cycle in IDLE, so there is a 1-cycle bubble between owners. The same engine can be re-granted immediately if it is still the candidate.
- Simultaneous wready and rready in one cycle: both route to the owner; burst_cnt increments by 1.

## Configuration
- GENIE_ARB_PERF_EN:
  - Defined: each engine has a 32-bit saturating counter that increments on each of its wready or rready pulses (+2 if both in one cycle); perf_cnt = counter[perf_sel].
  - Undefined: no counters; perf_cnt is constant 0 and perf_sel is ignored.

## Structure
- constants.v gains ARB_MODE_STATIC (0), ARB_MODE_RR (1), ARB_IDLE and ARB_OWN.
- Existing LAYER_* codes double as engine indices, so the decoder drives sel with the layer type directly.
- One sub-module: RRPicker (combinational rotate-priority encoder: request vector, pointer in → index and found flag out).

## Test plan
- Static mode, sel=1, engine 1 issues a read to 0x100, memory answers rready with 0xDEADBEEF two cycles later → e_rready[1] pulses with e_rdata[1]=0xDEADBEEF; other engines see rready 0 and rdata 0.
- Round-robin mode, engines 0 and 2 request continuously, BURST=4 → grants alternate 0,2,0, each after 4 completions, with a 1-cycle IDLE between owners.
- Round-robin mode, only engine 3 requests → it stays owner beyond BURST and burst_cnt saturates at 4.
- Static mode, sel changes 1→2 while a write is in flight → ownership stays with engine 1 until wready, then IDLE, then engine 2.
- rst_n asserted mid-read → all outputs 0 immediately; after release, the first request is granted after one IDLE cycle with rr_ptr=0.
- GENIE_ARB_PERF_EN defined, engine 0 completes 5 reads and 3 writes → perf_sel=0 reads 8; undefined → perf_cnt reads 0.
